// File: rtl/seq_ctrl_unit.sv
// -----------------------------------------------------------------------------
// seq_ctrl_unit
//   Multi-cycle sequencer for the 16-bit ISA. Owns the PC, which drives the
//   combinational instruction memory directly. Every instruction passes through
//   FETCH -> DECODE -> EXEC -> WB, so each one takes exactly four cycles. The
//   unit also handles the zero flag for BRZ and the start, stop and halt
//   controls.
//
// Ports
//   clk, rst        rising-edge clock and synchronous active-high reset
//   start           pulse that begins execution at RST_PC (from IDLE or HALT)
//   stop            requests a halt once the instruction in flight completes
//   imem_addr       instruction-memory address; always equal to the PC
//   imem_instr      instruction word returned for imem_addr
//   alu_zero        datapath zero result, sampled at the end of WB
//   rf_ra/rb/wa     register-file read and write addresses
//   rf_we           register-file write enable, high only during WB
//   alu_op          00 MUL, 01 XNOR, 10 PASS_A, 11 PASS_IMM
//   imm             LDI immediate
//   busy            high in FETCH/DECODE/EXEC/WB
//   halted          high in HALT
//   illegal         sticky flag: an undefined opcode was fetched
// -----------------------------------------------------------------------------
module seq_ctrl_unit #(
  parameter int PC_W       = 8,
  parameter int RST_PC     = 0,
  parameter int STEP_LIMIT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_instr,
  input  logic            alu_zero,
  output logic [3:0]      rf_ra,
  output logic [3:0]      rf_rb,
  output logic [3:0]      rf_wa,
  output logic            rf_we,
  output logic [1:0]      alu_op,
  output logic [7:0]      imm,
  output logic            busy,
  output logic            halted,
  output logic            illegal
);

  localparam logic [3:0] OP_MUL  = 4'b0000;
  localparam logic [3:0] OP_XNOR = 4'b0010;
  localparam logic [3:0] OP_MOV  = 4'b0100;
  localparam logic [3:0] OP_BRZ  = 4'b0110;
  localparam logic [3:0] OP_LDI  = 4'b1000;

  localparam logic [PC_W-1:0] RST_PC_V = PC_W'(RST_PC);
  localparam logic [31:0]     LIMIT_V  = 32'(STEP_LIMIT);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // True for the five defined opcodes.
  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_MUL, OP_XNOR, OP_MOV, OP_BRZ, OP_LDI: op_legal = 1'b1;
      default:                                 op_legal = 1'b0;
    endcase
  endfunction

  // True for opcodes that write the register file (everything except BRZ).
  function automatic logic op_writes(input logic [3:0] op);
    case (op)
      OP_MUL, OP_XNOR, OP_MOV, OP_LDI: op_writes = 1'b1;
      default:                         op_writes = 1'b0;
    endcase
  endfunction

  // Maps an opcode to the ALU function it needs; BRZ does not use the ALU.
  function automatic logic [1:0] op_alu(input logic [3:0] op);
    case (op)
      OP_MUL:  op_alu = 2'b00;
      OP_XNOR: op_alu = 2'b01;
      OP_MOV:  op_alu = 2'b10;
      OP_LDI:  op_alu = 2'b11;
      default: op_alu = 2'b00;
    endcase
  endfunction

  state_t            state_r;
  state_t            state_nx_s;
  logic [PC_W-1:0]   pc_r;
  logic [15:0]       ir_r;
  logic              z_flag_r;
  logic [31:0]       step_cnt_r;
  logic              stop_pend_r;
  logic [3:0]        rf_ra_r;
  logic [3:0]        rf_rb_r;
  logic [3:0]        rf_wa_r;
  logic              rf_we_r;
  logic [1:0]        alu_op_r;
  logic [7:0]        imm_r;
  logic              busy_r;
  logic              halted_r;
  logic              illegal_r;

  logic [3:0]        op_s;
  logic              legal_s;
  logic              writer_s;
  logic              limit_hit_s;
  logic              busy_nx_s;
  logic              halted_nx_s;
  logic              rf_we_nx_s;

  assign imem_addr = pc_r;
  assign rf_ra     = rf_ra_r;
  assign rf_rb     = rf_rb_r;
  assign rf_wa     = rf_wa_r;
  assign rf_we     = rf_we_r;
  assign alu_op    = alu_op_r;
  assign imm       = imm_r;
  assign busy      = busy_r;
  assign halted    = halted_r;
  assign illegal   = illegal_r;

  // Decode of the latched instruction and the step-limit comparison.
  always_comb begin
    op_s     = ir_r[15:12];
    legal_s  = op_legal(op_s);
    writer_s = op_writes(op_s);
    // The WB in progress is the one that reaches the limit.
    if (LIMIT_V != 32'd0) begin
      limit_hit_s = ((step_cnt_r + 32'd1) >= LIMIT_V);
    end else begin
      limit_hit_s = 1'b0;
    end
  end

  // Next-state logic plus the next values of the state-derived outputs.
  always_comb begin
    state_nx_s  = state_r;
    busy_nx_s   = 1'b0;
    halted_nx_s = 1'b0;
    rf_we_nx_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nx_s = ST_FETCH;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_FETCH:  state_nx_s = ST_DECODE;
      ST_DECODE: begin
        if (legal_s) begin
          state_nx_s = ST_EXEC;
        end else begin
          state_nx_s = ST_HALT;
        end
      end
      ST_EXEC:   state_nx_s = ST_WB;
      ST_WB: begin
        // A stop raised during WB itself still counts as seen.
        if (stop_pend_r || stop || limit_hit_s) begin
          state_nx_s = ST_HALT;
        end else begin
          state_nx_s = ST_FETCH;
        end
      end
      ST_HALT: begin
        if (start) begin
          state_nx_s = ST_FETCH;
        end else begin
          state_nx_s = ST_HALT;
        end
      end
      default:   state_nx_s = ST_IDLE;
    endcase
    // The outputs are registered from the next state, so they line up with it.
    busy_nx_s   = (state_nx_s == ST_FETCH) || (state_nx_s == ST_DECODE) ||
                  (state_nx_s == ST_EXEC)  || (state_nx_s == ST_WB);
    halted_nx_s = (state_nx_s == ST_HALT);
    rf_we_nx_s  = (state_nx_s == ST_WB) && writer_s;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // PC, instruction register, flags, step counter and registered controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r        <= RST_PC_V;
      ir_r        <= 16'd0;
      z_flag_r    <= 1'b0;
      step_cnt_r  <= 32'd0;
      stop_pend_r <= 1'b0;
      rf_ra_r     <= 4'd0;
      rf_rb_r     <= 4'd0;
      rf_wa_r     <= 4'd0;
      rf_we_r     <= 1'b0;
      alu_op_r    <= 2'b00;
      imm_r       <= 8'd0;
      busy_r      <= 1'b0;
      halted_r    <= 1'b0;
      illegal_r   <= 1'b0;
    end else begin
      busy_r   <= busy_nx_s;
      halted_r <= halted_nx_s;
      rf_we_r  <= rf_we_nx_s;
      case (state_r)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            pc_r        <= RST_PC_V;
            z_flag_r    <= 1'b0;
            illegal_r   <= 1'b0;
            step_cnt_r  <= 32'd0;
            // Start takes priority; a simultaneous stop is kept as pending.
            stop_pend_r <= stop;
          end
        end
        ST_FETCH: begin
          ir_r        <= imem_instr;
          stop_pend_r <= stop_pend_r | stop;
        end
        ST_DECODE: begin
          if (legal_s) begin
            rf_wa_r     <= ir_r[11:8];
            rf_ra_r     <= ir_r[7:4];
            rf_rb_r     <= ir_r[3:0];
            imm_r       <= ir_r[7:0];
            alu_op_r    <= op_alu(op_s);
            stop_pend_r <= stop_pend_r | stop;
          end else begin
            // Straight to HALT; pc and the zero flag stay where they are.
            illegal_r   <= 1'b1;
            stop_pend_r <= 1'b0;
          end
        end
        ST_EXEC: begin
          if ((op_s == OP_BRZ) && z_flag_r) begin
            pc_r <= PC_W'(ir_r[7:0]);
          end else begin
            pc_r <= pc_r + PC_W'(1);
          end
          stop_pend_r <= stop_pend_r | stop;
        end
        ST_WB: begin
          if (writer_s) begin
            z_flag_r <= alu_zero;
          end
          step_cnt_r  <= step_cnt_r + 32'd1;
          // Any pending stop is consumed by the transition out of WB.
          stop_pend_r <= 1'b0;
        end
        default: begin
          stop_pend_r <= stop_pend_r;
        end
      endcase
    end
  end

endmodule
